mem_bank_cfg_sequencer: RTL and testbench

MEM_BANK_CFG_SEQUENCER -- requirements
Module: mem_bank_cfg_sequencer

---
 rtl/mem_bank_cfg_sequencer.sv | 125 ++++++++++++
 tb/tb_mem_bank_cfg_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bank_cfg_sequencer.sv
// Purpose : programs a memory tile row by row: takes one row word per row, drives bit lines, then pulses that row's word line.
// Latency : 3+WL_PULSE cycles per row with cfg_valid held high, plus one DONE cycle; done is asserted 16 cycles after start with the default parameters.
// Backpressure: cfg_ready is high only in LOAD. While cfg_valid is low, the sequencer waits in LOAD with bl and wl held.
//
// Ports:
//   prog_clk, prog_reset_n : clock, and a synchronous active-low reset
//   start                  : single-cycle request to program all rows; honoured only in IDLE
//   cfg_valid/cfg_ready    : handshake for the row word on cfg_data (cfg_data[i] drives bl[i])
//   bl, wl                 : registered bit-line and word-line drive; wl is one-hot or zero
//   busy, done             : busy is high outside IDLE; done pulses for the final DONE cycle
module mem_bank_cfg_sequencer #(
    parameter int BL_WIDTH = 3,
    parameter int WL_WIDTH = 3,
    parameter int WL_PULSE = 2
) (
    input  logic                prog_clk,
    input  logic                prog_reset_n,
    input  logic                start,
    input  logic                cfg_valid,
    input  logic [0:BL_WIDTH-1] cfg_data,
    output logic                cfg_ready,
    output logic [0:BL_WIDTH-1] bl,
    output logic [0:WL_WIDTH-1] wl,
    output logic                busy,
    output logic                done
);

    localparam int              ROW_W     = (WL_WIDTH > 1) ? $clog2(WL_WIDTH) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(WL_WIDTH - 1);
    localparam logic [7:0]      PULSE_LEN = 8'(WL_PULSE);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETUP,
        PULSE,
        HOLD,
        DONE
    } state_t;

    state_t              state, state_nxt;
    logic [ROW_W-1:0]    row, row_nxt;
    logic [7:0]          pcnt, pcnt_nxt;
    logic [0:BL_WIDTH-1] bl_nxt;
    logic [0:WL_WIDTH-1] wl_nxt;

    always_ff @(posedge prog_clk) begin
        if (!prog_reset_n) begin
            state <= IDLE;
            row   <= '0;
            pcnt  <= '0;
            bl    <= '0;
            wl    <= '0;
        end else begin
            state <= state_nxt;
            row   <= row_nxt;
            pcnt  <= pcnt_nxt;
            bl    <= bl_nxt;
            wl    <= wl_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        row_nxt   = row;
        pcnt_nxt  = pcnt;
        bl_nxt    = bl;
        wl_nxt    = '0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD;
                    row_nxt   = '0;
                end
            end
            LOAD: begin
                if (cfg_valid) begin
                    bl_nxt    = cfg_data;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                pcnt_nxt  = PULSE_LEN;
                state_nxt = PULSE;
            end
            PULSE: begin
                // The counter holds the number of pulse cycles left, including the current cycle.
                if (pcnt <= 8'd1) begin
                    pcnt_nxt  = '0;
                    state_nxt = HOLD;
                end else begin
                    pcnt_nxt = pcnt - 8'd1;
                end
            end
            HOLD: begin
                if (row == LAST_ROW) begin
                    state_nxt = DONE;
                end else begin
                    row_nxt   = row + 1'b1;
                    state_nxt = LOAD;
                end
            end
            DONE: begin
                bl_nxt    = '0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // wl is registered, so it is decoded from the next state.
        // This keeps wl high in exactly the PULSE cycles.
        // The row is stable when entering PULSE and throughout PULSE.
        if (state_nxt == PULSE) begin
            for (int i = 0; i < WL_WIDTH; i++) begin
                wl_nxt[i] = (row == ROW_W'(i));
            end
        end
    end

    assign cfg_ready = (state == LOAD);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_mem_bank_cfg_sequencer.sv
// Purpose : self-checking bench for mem_bank_cfg_sequencer with default parameters (3 rows, 3 bit lines, pulse of 2).
// Latency : expects done 16 cycles after start, plus one cycle per cycle that cfg_valid is stalled.
// Backpressure: drives cfg_valid low for a number of cycles in one row's LOAD state.
module tb_mem_bank_cfg_sequencer;

    localparam int P       = 2;
    localparam int ROW_CYC = 3 + P;
    localparam int FULL    = 3 * ROW_CYC + 1;

    logic       prog_clk = 1'b0;
    logic       prog_reset_n;
    logic       start;
    logic       cfg_valid;
    logic [0:2] cfg_data;
    logic       cfg_ready;
    logic [0:2] bl;
    logic [0:2] wl;
    logic       busy;
    logic       done;

    mem_bank_cfg_sequencer #(
        .BL_WIDTH (3),
        .WL_WIDTH (3),
        .WL_PULSE (P)
    ) dut (
        .prog_clk     (prog_clk),
        .prog_reset_n (prog_reset_n),
        .start        (start),
        .cfg_valid    (cfg_valid),
        .cfg_data     (cfg_data),
        .cfg_ready    (cfg_ready),
        .bl           (bl),
        .wl           (wl),
        .busy         (busy),
        .done         (done)
    );

    always #5 prog_clk = ~prog_clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [0:2] oh(input int r);
        logic [0:2] v;
        v    = '0;
        v[r] = 1'b1;
        return v;
    endfunction

    typedef struct packed {
        logic [0:2] wl;
        logic [0:2] bl;
    } pulse_t;

    pulse_t     exp_q[$];
    int         done_cnt = 0;
    logic [0:2] prev_bl  = '0;
    logic       mon_en   = 1'b0;
    pulse_t     e;

    // Checks that run on every cycle. Each word-line pulse is taken from the scoreboard.
    always @(negedge prog_clk) begin
        if (mon_en) begin
            if (done) begin
                done_cnt++;
                chk("done_busy", busy, 1);
            end
            chk("wl_onehot0", $onehot0(wl), 1);
            if (wl != '0) begin
                chk("bl_stable", bl, prev_bl);
                if (exp_q.size() == 0) begin
                    chk("wl_unexpected", wl, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse", {wl, bl}, e);
                end
            end
            prev_bl = bl;
        end
    end

    task automatic run_prog(input logic [0:2] r0, input logic [0:2] r1, input logic [0:2] r2,
                            input int stall_row, input int stall_n, input int abort_row,
                            input bit skip_start, input bit poke_start, input int exp_len);
        logic [0:2] rows [3];
        int         idx     = 0;
        int         stalled = 0;
        int         busy_n  = 0;
        bit         fin     = 0;
        rows[0] = r0;
        rows[1] = r1;
        rows[2] = r2;
        cfg_valid = 1'b1;
        cfg_data  = r0;
        if (!skip_start) start = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        for (int n = 1; n <= 200 && !fin; n++) begin
            if (done) begin
                chk("done_cycle", n, exp_len);
                chk("busy_cycles", busy_n, exp_len - 1);
                if (poke_start) start = 1'b1;
                fin = 1;
            end else begin
                if (busy) busy_n++;
                if (abort_row >= 0 && wl == oh(abort_row)) begin
                    prog_reset_n = 1'b0;
                    @(negedge prog_clk);
                    chk("abort_wl", wl, 0);
                    chk("abort_bl", bl, 0);
                    chk("abort_done", done, 0);
                    chk("abort_busy", busy, 0);
                    chk("abort_rdy", cfg_ready, 0);
                    prog_reset_n = 1'b1;
                    exp_q.delete();
                    fin = 1;
                end else begin
                    if (cfg_ready) begin
                        if (idx >= 3) begin
                            chk("extra_load", idx, 2);
                        end else if (idx == stall_row && stalled < stall_n) begin
                            cfg_valid = 1'b0;
                            cfg_data  = ~rows[idx];
                            chk("stall_wl", wl, 0);
                            chk("stall_bl", bl, rows[idx-1]);
                            stalled++;
                        end else begin
                            cfg_valid = 1'b1;
                            cfg_data  = rows[idx];
                            for (int k = 0; k < P; k++) exp_q.push_back({oh(idx), rows[idx]});
                            idx++;
                        end
                    end
                    if (poke_start && n == 3) start = 1'b1;
                    if (poke_start && n == 4) start = 1'b0;
                    @(negedge prog_clk);
                end
            end
        end
        if (!fin) chk("timeout", 0, 1);
    endtask

    task automatic after_done(input int d0);
        @(negedge prog_clk);
        chk("done_single", done, 0);
        chk("done_count", done_cnt, d0 + 1);
        chk("bl_cleared", bl, 0);
        chk("sb_empty", exp_q.size(), 0);
    endtask

    int d0;

    initial begin
        prog_reset_n = 1'b0;
        start        = 1'b1;
        cfg_valid    = 1'b1;
        cfg_data     = 3'b111;
        @(negedge prog_clk);
        chk("rst_bl", bl, 0);
        chk("rst_wl", wl, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rdy", cfg_ready, 0);
        @(negedge prog_clk);
        chk("rst2_busy", busy, 0);
        chk("rst2_wl", wl, 0);
        start        = 1'b0;
        cfg_valid    = 1'b0;
        prog_reset_n = 1'b1;
        mon_en       = 1'b1;
        @(negedge prog_clk);
        chk("idle_busy", busy, 0);

        // Full program with cfg_valid always high.
        d0 = done_cnt;
        run_prog(3'b101, 3'b011, 3'b110, -1, 0, -1, 0, 0, FULL);
        after_done(d0);

        // Stall for four cycles in row 1's LOAD.
        d0 = done_cnt;
        run_prog(3'b101, 3'b011, 3'b110, 1, 4, -1, 0, 0, FULL + 4);
        after_done(d0);

        // Reset during row 1's pulse. This must not produce a done pulse.
        d0 = done_cnt;
        run_prog(3'b111, 3'b010, 3'b100, -1, 0, 1, 0, 0, FULL);
        @(negedge prog_clk);
        chk("abort_no_done", done_cnt, d0);
        chk("abort_idle", busy, 0);

        // After the reset, a new program starts from row 0.
        d0 = done_cnt;
        run_prog(3'b010, 3'b111, 3'b001, -1, 0, -1, 0, 0, FULL);
        after_done(d0);

        // start is ignored while busy and in DONE. It is accepted in the first IDLE cycle.
        d0 = done_cnt;
        run_prog(3'b110, 3'b001, 3'b101, -1, 0, -1, 0, 1, FULL);
        @(negedge prog_clk);
        chk("start_in_done_ignored", busy, 0);
        chk("done_single2", done, 0);
        chk("done_count2", done_cnt, d0 + 1);
        d0 = done_cnt;
        run_prog(3'b011, 3'b100, 3'b111, -1, 0, -1, 1, 0, FULL);
        after_done(d0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
